// File: rtl/conv_pkg.sv
// conv_pkg: shared lane/width parameters and state encoding for the psum accumulator
package conv_pkg;
  localparam int LANES = 4;
  localparam int PSUM_W = 8;
  localparam int ACC_W = 20;
  localparam int MAX_PIX = 1024;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
endpackage

// File: rtl/acc_buffer.sv
// acc_buffer: per-pixel accumulator storage with async read and sync write
module acc_buffer import conv_pkg::*; #(
  parameter int DEPTH = MAX_PIX,
  parameter int WIDTH = LANES * ACC_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  // contents are never cleared; the first pass of a group overwrites instead of accumulating
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates lane partial sums across input-channel passes and writes clamped results
module psum_accumulator import conv_pkg::*; #(
  parameter int LANES = conv_pkg::LANES,
  parameter int PSUM_W = conv_pkg::PSUM_W,
  parameter int ACC_W = conv_pkg::ACC_W,
  parameter int MAX_PIX = conv_pkg::MAX_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              init_signal,
  input  logic [15:0]       WxW_out,
  input  logic [11:0]       channel_input_img,
  input  logic [10:0]       no_channel_out,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum_0,
  input  logic [PSUM_W-1:0] psum_1,
  input  logic [PSUM_W-1:0] psum_2,
  input  logic [PSUM_W-1:0] psum_3,
  output logic              out_we,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done
);
  localparam int AW = $clog2(MAX_PIX);
  state_e state_q, state_d;
  logic [15:0] w_q, w_d, p_q, p_d;
  logic [11:0] cin_q, cin_d, c_q, c_d;
  logic [10:0] cout_q, cout_d, g_q, g_d;
  logic out_we_q, out_we_d;
  logic [31:0] out_addr_q, out_addr_d, out_data_q, out_data_d;
  logic [LANES-1:0][PSUM_W-1:0] ps;
  logic [LANES-1:0][ACC_W-1:0] rd, wd;
  logic [LANES-1:0][7:0] clamp;
  logic start, cfg_zero, accept, beat, p_last, c_last, g_last;
  assign ps = {psum_3, psum_2, psum_1, psum_0};
  assign start = en && init_signal;
  assign cfg_zero = WxW_out == '0 || channel_input_img == '0 || no_channel_out == '0;
  assign psum_ready = en && state_q == ACCUM;
  assign accept = psum_valid && psum_ready;
  assign beat = accept && !init_signal;
  assign p_last = p_q == w_q - 16'd1;
  assign c_last = c_q == cin_q - 12'd1;
  assign g_last = g_q == cout_q - 11'd1;
  acc_buffer #(.DEPTH(MAX_PIX), .WIDTH(LANES * ACC_W)) u_buf (
    .clk   (clk),
    .we    (beat),
    .addr  (p_q[AW-1:0]),
    .wdata (wd),
    .rdata (rd)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: a start pulse wins over everything, including a beat in the same cycle
  always_comb begin
    state_d = start ? (cfg_zero ? DONE : ACCUM) :
              (en && state_q == DONE) ? IDLE :
              (beat && p_last && c_last && g_last) ? DONE : state_q;
  end
  // status outputs decoded from state
  always_comb begin
    busy = state_q == ACCUM;
    done = state_q == DONE;
  end
  // lane sums: first pass starts from zero, later passes add to the stored value, then clamp to 0..127
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      wd[k] = (c_q == '0 ? '0 : rd[k]) + {{(ACC_W-PSUM_W){ps[k][PSUM_W-1]}}, ps[k]};
      clamp[k] = wd[k][ACC_W-1] ? 8'd0 : |wd[k][ACC_W-2:7] ? 8'd127 : wd[k][7:0];
    end
  end
  // counters, config latch and registered write port
  always_comb begin
    w_d = start ? WxW_out : w_q;
    cin_d = start ? channel_input_img : cin_q;
    cout_d = start ? no_channel_out : cout_q;
    p_d = start ? '0 : beat ? (p_last ? '0 : p_q + 16'd1) : p_q;
    c_d = start ? '0 : (beat && p_last) ? (c_last ? '0 : c_q + 12'd1) : c_q;
    g_d = start ? '0 : (beat && p_last && c_last) ? (g_last ? '0 : g_q + 11'd1) : g_q;
    out_we_d = beat && c_last;
    out_addr_d = out_we_d ? 32'(g_q) * 32'(w_q) + 32'(p_q) : out_addr_q;
    out_data_d = out_we_d ? clamp : out_data_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      cin_q <= '0;
      cout_q <= '0;
      p_q <= '0;
      c_q <= '0;
      g_q <= '0;
      out_we_q <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      w_q <= w_d;
      cin_q <= cin_d;
      cout_q <= cout_d;
      p_q <= p_d;
      c_q <= c_d;
      g_q <= g_d;
      out_we_q <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_we = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: randomized scoreboard bench for psum_accumulator
module tb_psum_accumulator;
  logic clk = 0, rst = 1, en = 1, init_signal = 0;
  logic [15:0] WxW_out = 0;
  logic [11:0] channel_input_img = 0;
  logic [10:0] no_channel_out = 0;
  logic psum_valid = 0, psum_ready;
  logic [7:0] psum_0 = 0, psum_1 = 0, psum_2 = 0, psum_3 = 0;
  logic out_we, busy, done;
  logic [31:0] out_addr, out_data;
  logic exp_last = 0, pend_we = 0;
  int n_chk = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0, ready_cnt = 0;
  logic [63:0] q[$];
  logic [63:0] e;
  bit ab;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .en(en), .init_signal(init_signal),
    .WxW_out(WxW_out), .channel_input_img(channel_input_img), .no_channel_out(no_channel_out),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_0(psum_0), .psum_1(psum_1), .psum_2(psum_2), .psum_3(psum_3),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ready"}, 32'(psum_ready), 0);
    chk({name, "_we"}, 32'(out_we), 0);
    chk({name, "_addr"}, out_addr, 0);
    chk({name, "_data"}, out_data, 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
  endtask

  // monitor: out_we must follow exactly the accepted last-pass beats; each write pops the scoreboard
  always @(negedge clk) begin
    chk("we_timing", 32'(out_we), 32'(pend_we));
    if (out_we) begin
      wr_cnt++;
      if (q.size() == 0) chk("unexpected_write", 32'(out_addr), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("addr", out_addr, e[63:32]);
        chk("data", out_data, e[31:0]);
      end
    end
    if (done) done_cnt++;
    if (psum_ready) ready_cnt++;
    pend_we = psum_valid && psum_ready && exp_last && !init_signal && !rst;
  end

  task automatic run_layer(input int w, input int cin, input int cout, input int mode,
                           input int stall_at, input int rst_at, output bit aborted);
    int v[4][16][4];
    int beat, t, s;
    logic [31:0] d;
    aborted = 0;
    beat = 0;
    q.delete();
    wr_cnt = 0;
    done_cnt = 0;
    WxW_out = 16'(w);
    channel_input_img = 12'(cin);
    no_channel_out = 11'(cout);
    init_signal = 1;
    @(posedge clk); #1;
    init_signal = 0;
    WxW_out = 16'($urandom);
    channel_input_img = 12'($urandom);
    no_channel_out = 11'($urandom);
    chk("busy_start", 32'(busy), 1);
    for (int g = 0; g < cout; g++) begin
      for (int c = 0; c < cin; c++)
        for (int p = 0; p < w; p++)
          for (int k = 0; k < 4; k++)
            v[c][p][k] = mode == 1 ? 3 : (mode == 2 && k == 0) ? -5 :
                         (mode == 2 && k == 1) ? 100 : int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < cin; c++) begin
        for (int p = 0; p < w; p++) begin
          if (beat == rst_at) begin
            psum_valid = 0;
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            @(negedge clk);
            check_reset("rst_mid");
            q.delete();
            aborted = 1;
            return;
          end
          if ($urandom_range(0, 3) == 0) begin
            psum_valid = 0;
            psum_0 = 8'($urandom);
            @(posedge clk); #1;
          end
          psum_valid = 1;
          exp_last = c == cin - 1;
          psum_0 = 8'(v[c][p][0]);
          psum_1 = 8'(v[c][p][1]);
          psum_2 = 8'(v[c][p][2]);
          psum_3 = 8'(v[c][p][3]);
          if (beat == stall_at) begin
            en = 0;
            repeat (5) begin
              @(negedge clk);
              chk("ready_stall", 32'(psum_ready), 0);
              @(posedge clk); #1;
            end
            en = 1;
          end
          t = 0;
          @(negedge clk);
          while (!psum_ready && t < 20) begin
            @(negedge clk);
            t++;
          end
          if (!psum_ready) begin
            chk("accept_timeout", 32'(psum_ready), 1);
            psum_valid = 0;
            exp_last = 0;
            aborted = 1;
            return;
          end
          if (c == cin - 1) begin
            d = 0;
            for (int k = 0; k < 4; k++) begin
              s = 0;
              for (int c2 = 0; c2 < cin; c2++) s += v[c2][p][k];
              s = s < 0 ? 0 : s > 127 ? 127 : s;
              d[8*k +: 8] = 8'(s);
            end
            q.push_back({32'(g * w + p), d});
          end
          @(posedge clk); #1;
          psum_valid = 0;
          exp_last = 0;
          beat++;
        end
      end
    end
    chk("done_early", 32'(done_cnt), 0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 1);
    chk("write_count", 32'(wr_cnt), 32'(w * cout));
    chk("queue_empty", 32'(q.size()), 0);
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 0;
    run_layer(9, 2, 1, 1, -1, -1, ab);
    run_layer(9, 2, 1, 2, -1, -1, ab);
    run_layer(4, 1, 2, 0, -1, -1, ab);
    run_layer(9, 2, 2, 0, 10, -1, ab);
    wr_cnt = 0;
    done_cnt = 0;
    ready_cnt = 0;
    WxW_out = 0;
    channel_input_img = 2;
    no_channel_out = 1;
    psum_valid = 1;
    exp_last = 1;
    init_signal = 1;
    @(posedge clk); #1;
    init_signal = 0;
    repeat (4) @(negedge clk);
    chk("zero_done", 32'(done_cnt), 1);
    chk("zero_writes", 32'(wr_cnt), 0);
    chk("zero_ready", 32'(ready_cnt), 0);
    @(posedge clk); #1;
    psum_valid = 0;
    exp_last = 0;
    run_layer(9, 2, 1, 1, -1, 7, ab);
    chk("rst_aborted", 32'(ab), 1);
    run_layer(9, 2, 1, 1, -1, -1, ab);
    for (int i = 0; i < 4; i++)
      run_layer($urandom_range(1, 16), $urandom_range(1, 4), $urandom_range(1, 3), 0,
                $urandom_range(0, 8), -1, ab);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning parallel output-channel lanes per group.
REQ-002 SHALL have parameter PSUM_W, default 8, meaning signed partial-sum width per lane.
REQ-003 SHALL have parameter ACC_W, default 20, meaning signed accumulator width per lane.
REQ-004 SHALL have parameter MAX_PIX, default 1024, meaning accumulation-buffer depth (max WxW_out).
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: en in 1, global enable (low freezes all state); init_signal in 1, layer start pulse.
REQ-007 SHALL have ports: WxW_out in 16, output pixels per channel group; channel_input_img in 12, input channel groups (accumulation passes); no_channel_out in 11, output channel groups.
REQ-008 SHALL have ports: psum_valid in 1; psum_ready out 1; psum_0..psum_3 in PSUM_W each, signed lane partial sums.
REQ-009 SHALL have ports: out_we out 1; out_addr out 32, word address; out_data out 32, lane k in bits [8k+7:8k].
REQ-010 SHALL have ports: busy out 1, high in ACCUM; done out 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, ACCUM, DONE; all transitions and updates only when en=1.
REQ-012 SHALL go IDLE->ACCUM on init_signal, clearing pixel counter p, pass counter c and group counter g, and latching the three config inputs.
REQ-013 SHALL go IDLE->DONE on init_signal when any latched config value is zero, with no writes.
REQ-014 SHALL assert psum_ready only in ACCUM with en=1; a beat is accepted on psum_valid && psum_ready.
REQ-015 SHALL on an accepted beat, per lane, write buf[p] = (c==0 ? 0 : buf[p]) + sign_extend(psum_k) to ACC_W bits.
REQ-016 SHALL advance p per accepted beat; p wraps at WxW_out-1 and increments c; c wraps at channel_input_img-1 and increments g.
REQ-017 SHALL when c is the last pass, register out_we=1 one cycle after acceptance, with out_addr = g*WxW_out + p and out_data = per-lane clamp(sum, 0, 127).
REQ-018 SHALL deassert out_we in every cycle following no accepted last-pass beat; out_we is never held longer than one cycle per beat.
REQ-019 SHALL go ACCUM->DONE on the accepted beat with p, c and g all at their last values; done=1 for exactly the DONE cycle, then DONE->IDLE.
REQ-020 SHALL on init_signal in ACCUM or DONE restart as in REQ-012; a beat accepted in that same cycle is discarded with no write.
REQ-021 SHALL keep psum_ready low in IDLE and DONE; psum_valid there is ignored.
REQ-022 SHALL not overflow: ACC_W=20 holds 4095 passes x |−128|.

Reset
REQ-023 SHALL on rst=1 set state IDLE, p=c=g=0, psum_ready=0, out_we=0, out_addr=0, out_data=0, busy=0, done=0; rst has priority over en and init_signal.
REQ-024 SHALL not clear buffer contents on reset; c==0 overwrite makes stale contents harmless.

Structure
REQ-025 SHALL take LANES, PSUM_W, ACC_W, MAX_PIX and the state enum from shared package conv_pkg.
REQ-026 SHALL place storage in one sub-module acc_buffer: MAX_PIX x (LANES*ACC_W), async read, sync write.

Verification
REQ-027 SHALL cover WxW_out=9, channel_input_img=2, no_channel_out=1, all psums=3 -> 9 writes, addr 0..8, every lane 6, done once after 18th beat.
REQ-028 SHALL cover a psum_k=-5 on both passes -> that lane writes 0; psum 100 on both passes -> 127 (clamp).
REQ-029 SHALL cover no_channel_out=2, WxW_out=4, channel_input_img=1 -> addresses 0..7, out_we one cycle after each accept.
REQ-030 SHALL cover en=0 for 5 cycles mid-pass -> psum_ready=0, counters frozen, results identical to uninterrupted run.
REQ-031 SHALL cover WxW_out=0 with init_signal -> done pulse 2 cycles later, zero writes, psum_ready never high.
REQ-032 SHALL cover rst=1 at beat 7 of 18 -> outputs at reset values next cycle; rerun after init_signal -> results as REQ-027.
